// File: rtl/pipeline_sequencer.sv
// Run/step/halt and hazard sequencer for a 5-stage MIPS pipeline.
// It owns every stage enable and drains the pipeline after a HALT opcode.
module pipeline_sequencer #(
  parameter logic [5:0] HALT_OPCODE  = 6'b111111,
  parameter int         DRAIN_CYCLES = 3,
  parameter int         CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  input  logic [5:0]       if_id_op,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rt,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             ctrl_enable,
  output logic             pipe_en,
  output logic             step_done,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_STEP   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_PAUSE = 2'b11;

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  logic [2:0]       state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_done_q, step_done_d;

  logic advance;
  logic load_use;
  logic halt_hit;
  logic cmd_accept;

  // Debug handshake: a command transfers on a cycle where cmd_valid and
  // cmd_ready are both 1; cmd is only looked at on that cycle.
  assign cmd_ready  = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign cmd_accept = cmd_valid && cmd_ready;

  assign advance  = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign load_use = id_ex_memread && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
  // A taken branch makes the IF/ID contents wrong-path, so HALT there is ignored.
  assign halt_hit = advance && !branch_taken && (if_id_op == HALT_OPCODE);

  // Front-end enables are combinational so a stall bites in the detecting cycle.
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    ctrl_enable = 1'b0;
    if (advance) begin
      if (branch_taken) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
      end else if (halt_hit || load_use) begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
      end else begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        ctrl_enable = 1'b1;
      end
    end
  end

  assign pipe_en = advance || (state_q == ST_DRAIN);

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    step_done_d = (state_q == ST_STEP);
    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          case (cmd)
            CMD_RUN:            state_d = ST_RUN;
            CMD_STEP:           state_d = ST_STEP;
            CMD_NOP, CMD_PAUSE: state_d = ST_IDLE;
            default:            state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (halt_hit) begin
          state_d = ST_DRAIN;
          drain_d = DW'(DRAIN_CYCLES);
        end else if (cmd_accept && (cmd == CMD_PAUSE)) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (halt_hit) begin
          state_d = ST_DRAIN;
          drain_d = DW'(DRAIN_CYCLES);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q - DW'(1);
        if (drain_q <= DW'(1)) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pipe_en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      drain_q     <= '0;
      cnt_q       <= '0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cnt_q       <= cnt_d;
      step_done_q <= step_done_d;
    end
  end

  assign step_done   = step_done_q;
  assign done        = (state_q == ST_HALTED);
  assign cycle_count = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: run/pause, hazards, halt/drain,
// single-step and counter saturation (on a narrow-counter second instance).
module tb_pipeline_sequencer;

  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_PAUSE = 2'b11;
  localparam logic [5:0] HALT_OP   = 6'b111111;
  localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_STEP = 3'd2,
                         S_DRAIN = 3'd3, S_HALTED = 3'd4;

  logic        clk, reset;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        cmd_ready;
  logic [5:0]  if_id_op;
  logic [4:0]  if_id_rs, if_id_rt, id_ex_rt;
  logic        id_ex_memread, branch_taken;
  logic        pc_en, if_id_en, if_id_flush, ctrl_enable, pipe_en;
  logic        step_done, done;
  logic [31:0] cycle_count;
  logic [2:0]  dbg_state;

  logic        reset2, cmd_valid2;
  logic [1:0]  cmd2;
  logic        s_ready, s_pc, s_ifid, s_flush, s_ctrl, s_pipe, s_sdone, s_done;
  logic [2:0]  s_cnt;
  logic [2:0]  s_state;

  logic [4:0]  en_v, s_en_v;
  assign en_v   = {pc_en, if_id_en, if_id_flush, ctrl_enable, pipe_en};
  assign s_en_v = {s_pc, s_ifid, s_flush, s_ctrl, s_pipe};

  int n_run  = 0;
  int n_fail = 0;

  pipeline_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .if_id_op(if_id_op), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt), .branch_taken(branch_taken),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .ctrl_enable(ctrl_enable), .pipe_en(pipe_en), .step_done(step_done), .done(done),
    .cycle_count(cycle_count), .dbg_state(dbg_state)
  );

  pipeline_sequencer #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset2), .cmd_valid(cmd_valid2), .cmd(cmd2), .cmd_ready(s_ready),
    .if_id_op(if_id_op), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt), .branch_taken(branch_taken),
    .pc_en(s_pc), .if_id_en(s_ifid), .if_id_flush(s_flush),
    .ctrl_enable(s_ctrl), .pipe_en(s_pipe), .step_done(s_sdone), .done(s_done),
    .cycle_count(s_cnt), .dbg_state(s_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    cyc();
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    cmd_valid = 1'b0; cmd = 2'b00; cmd_valid2 = 1'b0; cmd2 = 2'b00;
    if_id_op = 6'd0; if_id_rs = 5'd0; if_id_rt = 5'd0;
    id_ex_memread = 1'b0; id_ex_rt = 5'd0; branch_taken = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
    #1;
    check("rst_en", en_v, 5'b00000);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_step_done", step_done, 0);
    check("rst_cnt", cycle_count, 0);
    check("rst_state", dbg_state, S_IDLE);

    // Free run for 10 cycles, then PAUSE
    send_cmd(CMD_RUN);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("run_en", en_v, 5'b11011);
      check("run_ready", cmd_ready, 1);
      cyc();
    end
    #1 check("run_cnt10", cycle_count, 10);
    cmd_valid = 1'b1; cmd = CMD_PAUSE;
    #1 check("pause_cycle_en", en_v, 5'b11011);
    cyc();
    cmd_valid = 1'b0;
    #1;
    check("pause_en", en_v, 5'b00000);
    check("pause_ready", cmd_ready, 1);
    check("pause_state", dbg_state, S_IDLE);
    check("pause_cnt", cycle_count, 11);

    // Load-use hazards
    send_cmd(CMD_RUN);
    id_ex_memread = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
    #1 check("lu_rs_en", en_v, 5'b00001);
    cyc();
    id_ex_memread = 1'b0;
    #1 check("lu_release_en", en_v, 5'b11011);
    cyc();
    id_ex_memread = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0;
    #1 check("lu_rt0_en", en_v, 5'b11011);
    cyc();
    id_ex_rt = 5'd7; if_id_rt = 5'd7; if_id_rs = 5'd3;
    #1 check("lu_rt_match_en", en_v, 5'b00001);
    cyc();
    if_id_rt = 5'd4;
    #1 check("lu_nomatch_en", en_v, 5'b11011);
    cyc();

    // Branch beats load-use and HALT
    branch_taken = 1'b1; if_id_rt = 5'd7; if_id_op = HALT_OP;
    #1 check("br_en", en_v, 5'b11101);
    cyc();
    branch_taken = 1'b0; id_ex_memread = 1'b0; if_id_op = 6'd0;
    #1;
    check("br_state", dbg_state, S_RUN);
    check("br_after_en", en_v, 5'b11011);
    cyc();

    // HALT with a same-cycle PAUSE: HALT wins, then drain
    if_id_op = HALT_OP; cmd_valid = 1'b1; cmd = CMD_PAUSE;
    #1;
    check("halt_en", en_v, 5'b00001);
    check("halt_ready", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0; if_id_op = 6'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("drain_en", en_v, 5'b00001);
      check("drain_state", dbg_state, S_DRAIN);
      check("drain_ready", cmd_ready, 0);
      cyc();
    end
    #1;
    check("halted_done", done, 1);
    check("halted_en", en_v, 5'b00000);
    check("halted_ready", cmd_ready, 0);
    check("halted_cnt", cycle_count, 22);
    send_cmd(CMD_RUN);
    #1;
    check("halted_run_ignored", dbg_state, S_HALTED);
    check("halted_done_hold", done, 1);
    check("halted_cnt_hold", cycle_count, 22);

    // Single stepping
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("rst2_state", dbg_state, S_IDLE);
    check("rst2_cnt", cycle_count, 0);
    for (int k = 0; k < 3; k++) begin
      send_cmd(CMD_STEP);
      #1;
      check("step_ready", cmd_ready, 0);
      check("step_en", en_v, 5'b11011);
      check("step_state", dbg_state, S_STEP);
      cyc();
      #1;
      check("step_done_pulse", step_done, 1);
      check("step_idle_en", en_v, 5'b00000);
      check("step_idle_state", dbg_state, S_IDLE);
      cyc();
      #1 check("step_done_low", step_done, 0);
    end
    check("step_cnt3", cycle_count, 3);

    id_ex_memread = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5; if_id_rt = 5'd0;
    send_cmd(CMD_STEP);
    #1 check("step_stall_en", en_v, 5'b00001);
    cyc();
    id_ex_memread = 1'b0;
    #1 check("step_stall_state", dbg_state, S_IDLE);
    send_cmd(CMD_STEP);
    #1 check("step_adv_en", en_v, 5'b11011);
    cyc();
    #1 check("step_cnt5", cycle_count, 5);

    // STEP onto HALT, then reset in the 2nd drain cycle
    if_id_op = HALT_OP;
    send_cmd(CMD_STEP);
    #1 check("step_halt_en", en_v, 5'b00001);
    cyc();
    if_id_op = 6'd0;
    #1;
    check("step_halt_state", dbg_state, S_DRAIN);
    check("step_halt_done_pulse", step_done, 1);
    cyc();
    #1 check("drain2_state", dbg_state, S_DRAIN);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("abort_state", dbg_state, S_IDLE);
    check("abort_done", done, 0);
    check("abort_cnt", cycle_count, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_step_done", step_done, 0);

    // Saturation on a 3-bit counter instance
    reset2 = 1'b0;
    cmd_valid2 = 1'b1; cmd2 = CMD_RUN;
    cyc();
    cmd_valid2 = 1'b0;
    repeat (6) cyc();
    #1 check("sat_cnt6", s_cnt, 6);
    cyc();
    #1 check("sat_cnt7", s_cnt, 7);
    repeat (3) cyc();
    #1;
    check("sat_hold", s_cnt, 7);
    check("sat_en", s_en_v, 5'b11011);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
